// File: rtl/weight_loader.sv
// Weight-memory to 2x2 systolic array tile sequencer with a valid/ready output.
// Define WEIGHT_LOADER_TRANSPOSE_EN to transpose each tile on capture (row-wise storage).
module weight_loader #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_tiles,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_w1,
    input  logic [DATA_W-1:0] mem_w2,
    input  logic [DATA_W-1:0] mem_w3,
    input  logic [DATA_W-1:0] mem_w4,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_w11,
    output logic [DATA_W-1:0] out_w12,
    output logic [DATA_W-1:0] out_w21,
    output logic [DATA_W-1:0] out_w22,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    idx_q;
    logic [DATA_W-1:0]   w11_q, w12_q, w21_q, w22_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                busy_q;
    logic                done_q;

    logic [ADDR_W-1:0]   addr_next_d;
    logic [DATA_W-1:0]   w12_d, w21_d;
    logic                hs_d;

    always_comb begin
        // Address arithmetic wraps silently at 2^ADDR_W.
        addr_next_d = mem_addr_q + ADDR_W'(4);
        hs_d        = out_valid_q & out_ready;
`ifdef WEIGHT_LOADER_TRANSPOSE_EN
        w12_d = mem_w3;
        w21_d = mem_w2;
`else
        w12_d = mem_w2;
        w21_d = mem_w3;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            w11_q       <= '0;
            w12_q       <= '0;
            w21_q       <= '0;
            w22_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mem_addr_q <= base_addr;
                        cnt_q      <= num_tiles;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        if (num_tiles == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                // Memory samples mem_addr at the end of this cycle.
                S_ISSUE: begin
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    w11_q       <= mem_w1;
                    w12_q       <= w12_d;
                    w21_q       <= w21_d;
                    w22_q       <= mem_w4;
                    out_last_q  <= (cnt_q == CNT_W'(1));
                    out_valid_q <= 1'b1;
                    state_q     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (hs_d) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        cnt_q       <= cnt_q - CNT_W'(1);
                        idx_q       <= idx_q + CNT_W'(1);
                        mem_addr_q  <= addr_next_d;
                        if (out_last_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_w11   = w11_q;
    assign out_w12   = w12_q;
    assign out_w21   = w21_q;
    assign out_w22   = w22_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader with a registered-read weight memory model.
// Expected tiles follow the transpose build when WEIGHT_LOADER_TRANSPOSE_EN is defined.
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] base_addr;
    logic [7:0]  num_tiles;
    logic [12:0] mem_addr;
    logic [15:0] mem_w1, mem_w2, mem_w3, mem_w4;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_w11, out_w12, out_w21, out_w22;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int done_cnt = 0;

`ifdef WEIGHT_LOADER_TRANSPOSE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic [15:0] mem [0:8191];
    wire  [12:0] a1 = mem_addr + 13'd1;
    wire  [12:0] a2 = mem_addr + 13'd2;
    wire  [12:0] a3 = mem_addr + 13'd3;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_w1 <= mem[mem_addr];
        mem_w2 <= mem[a1];
        mem_w3 <= mem[a2];
        mem_w4 <= mem[a3];
        if (!reset && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
        if (!reset && done) done_cnt <= done_cnt + 1;
    end

    weight_loader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_tiles(num_tiles), .mem_addr(mem_addr),
        .mem_w1(mem_w1), .mem_w2(mem_w2), .mem_w3(mem_w3), .mem_w4(mem_w4),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_w11(out_w11), .out_w12(out_w12), .out_w21(out_w21), .out_w22(out_w22),
        .out_last(out_last), .busy(busy), .done(done)
    );

    function automatic logic [63:0] tile(input logic [15:0] a, b, c, d);
        return TR ? {a, c, b, d} : {a, b, c, d};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    // Drives start for cycle 0; on return the bench sits in cycle 1.
    task automatic launch(input logic [12:0] base, input logic [7:0] n);
        hs_cnt = 0;
        done_cnt = 0;
        start = 1'b1; base_addr = base; num_tiles = n;
        cyc();
        start = 1'b0; base_addr = 13'h1AAA; num_tiles = 8'hEE;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; num_tiles = '0;
        cyc(); cyc();
        checks++;
        if ({mem_addr, out_valid, out_last, busy, done} !== 17'd0) begin
            errors++; $display("FAIL reset_ctrl: got addr=%0d v=%b l=%b b=%b d=%b want all 0",
                               mem_addr, out_valid, out_last, busy, done);
        end
        checks++;
        if ({out_w11, out_w12, out_w21, out_w22} !== 64'd0) begin
            errors++; $display("FAIL reset_words: got %h want 0", {out_w11, out_w12, out_w21, out_w22});
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_single_tile();
        out_ready = 1'b1;
        launch(13'd15, 8'd1);
        checks++;
        if (mem_addr !== 13'd15 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL single_c1: got addr=%0d busy=%b v=%b want 15/1/0", mem_addr, busy, out_valid);
        end
        cyc(); cyc();
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL single_c3: got v=%b last=%b done=%b want 1/1/0", out_valid, out_last, done);
        end
        checks++;
        if ({out_w11, out_w12, out_w21, out_w22} !== tile(16'd3, 16'd5, 16'd4, 16'd6)) begin
            errors++; $display("FAIL single_words: got %h want %h",
                               {out_w11, out_w12, out_w21, out_w22}, tile(16'd3, 16'd5, 16'd4, 16'd6));
        end
        cyc();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_c4: got done=%b v=%b busy=%b want 1/0/1", done, out_valid, busy);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_c5: got done=%b busy=%b want 0/0", done, busy);
        end
        checks++;
        if ({out_w11, out_w12, out_w21, out_w22} !== tile(16'd3, 16'd5, 16'd4, 16'd6)) begin
            errors++; $display("FAIL single_hold: got %h want held tile", {out_w11, out_w12, out_w21, out_w22});
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        launch(13'd0, 8'd3);
        checks++;
        if (mem_addr !== 13'd0) begin
            errors++; $display("FAIL bp_addr0: got %0d want 0", mem_addr);
        end
        cyc(); cyc();
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b0 ||
            {out_w11, out_w12, out_w21, out_w22} !== tile(16'h100, 16'h101, 16'h102, 16'h103)) begin
            errors++; $display("FAIL bp_tile0: got v=%b l=%b w=%h", out_valid, out_last,
                               {out_w11, out_w12, out_w21, out_w22});
        end
        cyc();
        out_ready = 1'b0;
        checks++;
        if (mem_addr !== 13'd4 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_addr1: got addr=%0d v=%b want 4/0", mem_addr, out_valid);
        end
        cyc(); cyc();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_last !== 1'b0 || mem_addr !== 13'd4 ||
                {out_w11, out_w12, out_w21, out_w22} !== tile(16'h104, 16'h105, 16'h106, 16'h107)) begin
                errors++; $display("FAIL bp_stall%0d: got v=%b l=%b addr=%0d w=%h", i, out_valid, out_last,
                                   mem_addr, {out_w11, out_w12, out_w21, out_w22});
            end
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        checks++;
        if (mem_addr !== 13'd8 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_addr2: got addr=%0d v=%b want 8/0", mem_addr, out_valid);
        end
        cyc(); cyc();
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 ||
            {out_w11, out_w12, out_w21, out_w22} !== tile(16'h108, 16'h109, 16'h10A, 16'h10B)) begin
            errors++; $display("FAIL bp_tile2: got v=%b l=%b w=%h", out_valid, out_last,
                               {out_w11, out_w12, out_w21, out_w22});
        end
        cyc();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL bp_done: got %b want 1", done);
        end
        cyc(); cyc();
        checks++;
        if (hs_cnt !== 3 || done_cnt !== 1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_counts: got hs=%0d done=%0d busy=%b want 3/1/0", hs_cnt, done_cnt, busy);
        end
    endtask

    task automatic test_zero_tiles();
        out_ready = 1'b1;
        launch(13'd40, 8'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL zero_c1: got done=%b busy=%b v=%b want 1/1/0", done, busy, out_valid);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL zero_c2: got done=%b busy=%b v=%b want 0/0/0", done, busy, out_valid);
        end
        cyc(); cyc();
        checks++;
        if (hs_cnt !== 0 || done_cnt !== 1) begin
            errors++; $display("FAIL zero_counts: got hs=%0d done=%0d want 0/1", hs_cnt, done_cnt);
        end
    endtask

    task automatic test_addr_wrap();
        out_ready = 1'b1;
        launch(13'd8188, 8'd2);
        cyc(); cyc();
        checks++;
        if ({out_w11, out_w12, out_w21, out_w22} !== tile(16'h20FC, 16'h20FD, 16'h20FE, 16'h20FF)) begin
            errors++; $display("FAIL wrap_tile0: got %h", {out_w11, out_w12, out_w21, out_w22});
        end
        cyc();
        checks++;
        if (mem_addr !== 13'd0) begin
            errors++; $display("FAIL wrap_addr: got %0d want 0", mem_addr);
        end
        cyc(); cyc();
        checks++;
        if (out_last !== 1'b1 ||
            {out_w11, out_w12, out_w21, out_w22} !== tile(16'h100, 16'h101, 16'h102, 16'h103)) begin
            errors++; $display("FAIL wrap_tile1: got l=%b w=%h", out_last, {out_w11, out_w12, out_w21, out_w22});
        end
        cyc();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL wrap_done: got %b want 1", done);
        end
        cyc();
    endtask

    task automatic test_start_while_busy();
        out_ready = 1'b1;
        launch(13'd15, 8'd2);
        cyc();
        start = 1'b1; base_addr = 13'd100; num_tiles = 8'd5;
        cyc();
        checks++;
        if ({out_w11, out_w12, out_w21, out_w22} !== tile(16'd3, 16'd5, 16'd4, 16'd6) || mem_addr !== 13'd15) begin
            errors++; $display("FAIL swb_tile0: got addr=%0d w=%h", mem_addr, {out_w11, out_w12, out_w21, out_w22});
        end
        cyc();
        start = 1'b0;
        checks++;
        if (mem_addr !== 13'd19) begin
            errors++; $display("FAIL swb_addr1: got %0d want 19", mem_addr);
        end
        cyc(); cyc();
        checks++;
        if (out_last !== 1'b1 ||
            {out_w11, out_w12, out_w21, out_w22} !== tile(16'h113, 16'h114, 16'h115, 16'h116)) begin
            errors++; $display("FAIL swb_tile1: got l=%b w=%h", out_last, {out_w11, out_w12, out_w21, out_w22});
        end
        cyc();
        start = 1'b1; base_addr = 13'd200; num_tiles = 8'd1;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL swb_done: got %b want 1", done);
        end
        cyc();
        start = 1'b0;
        cyc();
        checks++;
        if (busy !== 1'b0 || done_cnt !== 1 || hs_cnt !== 2 || mem_addr !== 13'd23) begin
            errors++; $display("FAIL swb_after: got busy=%b done=%0d hs=%0d addr=%0d want 0/1/2/23",
                               busy, done_cnt, hs_cnt, mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        launch(13'd0, 8'd3);
        cyc(); cyc();
        cyc();
        out_ready = 1'b0;
        cyc(); cyc();
        checks++;
        if (out_valid !== 1'b1 || mem_addr !== 13'd4) begin
            errors++; $display("FAIL rmid_pre: got v=%b addr=%0d want 1/4", out_valid, mem_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_addr, out_valid, out_last, busy, done} !== 17'd0 ||
            {out_w11, out_w12, out_w21, out_w22} !== 64'd0) begin
            errors++; $display("FAIL rmid_async: got addr=%0d v=%b b=%b w=%h want 0",
                               mem_addr, out_valid, busy, {out_w11, out_w12, out_w21, out_w22});
        end
        cyc(); cyc();
        reset = 1'b0;
        cyc(); cyc();
        checks++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_nodone: got done=%0d busy=%b want 0/0", done_cnt, busy);
        end
        out_ready = 1'b1;
        launch(13'd15, 8'd1);
        cyc(); cyc();
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 ||
            {out_w11, out_w12, out_w21, out_w22} !== tile(16'd3, 16'd5, 16'd4, 16'd6)) begin
            errors++; $display("FAIL rmid_rerun: got v=%b l=%b w=%h", out_valid, out_last,
                               {out_w11, out_w12, out_w21, out_w22});
        end
        cyc();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL rmid_redone: got %b want 1", done);
        end
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0100 + 16'(i);
        mem[15] = 16'd3; mem[16] = 16'd5; mem[17] = 16'd4; mem[18] = 16'd6;
        test_reset();
        test_single_tile();
        test_backpressure();
        test_zero_tiles();
        test_addr_wrap();
        test_start_while_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
# weight_loader

Sequencer between the weight memory and the 2x2 systolic array. On a start pulse it fetches `num_tiles` consecutive 4-word weight tiles, starting at `base_addr`. It absorbs the memory's one-cycle registered read latency and presents each tile as a 2x2 block over a valid/ready handshake. It signals completion with a one-cycle `done` pulse.

## Interface
- `ADDR_W`, 13, memory word-address width
- `DATA_W`, 16, weight width
- `CNT_W`, 8, tile-count width
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  launch request; sampled only in IDLE
- `base_addr`  in  ADDR_W  address of first word of tile 0; sampled with `start`
- `num_tiles`  in  CNT_W  tiles to transfer; sampled with `start`
- `mem_addr`  out  ADDR_W  address to weight memory (registered)
- `mem_w1..mem_w4`  in  DATA_W each  memory read data for words addr..addr+3
- `out_valid`  out  1  tile available on `out_w*`
- `out_ready`  in  1  consumer accepts tile
- `out_w11, out_w12, out_w21, out_w22`  out  DATA_W each  tile as row/column 2x2 block
- `out_last`  out  1  current tile is the final one; qualified by `out_valid`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ISSUE, CAPTURE, PRESENT, DONE.
- IDLE:
  - On `start`=1, latch `base_addr` into `mem_addr` and `num_tiles` into the remaining count.
  - Clear the tile index. Go to ISSUE, or to DONE if `num_tiles`=0.
- ISSUE: `mem_addr` is stable for one cycle; the memory samples it at the closing edge. Go to CAPTURE.
- CAPTURE:
  - `mem_w1..4` are valid. Register them into the `out_w*` registers.
  - Set `out_last` = (remaining count == 1). Go to PRESENT.
- PRESENT:
  - `out_valid`=1. `out_w*` and `out_last` stay stable until the handshake (`out_valid` & `out_ready`) at a rising edge.
  - On handshake: decrement the count and set `mem_addr` <= `mem_addr` + 4.
  - Next state is DONE if this was the last tile, else ISSUE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Address arithmetic: modulo 2^ADDR_W. 8190 + 4 wraps to 2 with no error indication.
- `mem_addr` holds its value in every state except on a PRESENT handshake or an IDLE start.
- `start` outside IDLE is ignored. `start` in the DONE cycle is ignored; `start` is accepted again from IDLE.
- `out_w*` hold their last captured value after completion; only `out_valid` qualifies them.
- Default mapping: `out_w11`=w1, `out_w12`=w2, `out_w21`=w3, `out_w22`=w4.

## Timing
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - `mem_addr`, `out_w*`, the count and the index are cleared to 0.
  - `out_valid`, `out_last`, `busy` and `done` are 0.
  - An aborted transfer produces no `done`.
- `start` sampled in cycle 0. Then ISSUE in cycle 1, CAPTURE in cycle 2, first `out_valid` in cycle 3.
- With `out_ready` held at 1, each tile occupies 3 cycles (ISSUE, CAPTURE, PRESENT).
- For N>0 tiles, `done` is asserted in cycle 3N+1. For N=0, `done` is asserted in cycle 1.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- Backpressure: `out_ready`=0 stalls PRESENT indefinitely. No fetch is issued while stalled.
- `out_ready` asserted outside PRESENT has no effect.

## Configuration
- Macro `WEIGHT_LOADER_TRANSPOSE_EN`:
  - When defined, CAPTURE transposes the tile: `out_w12`=w3, `out_w21`=w2; `out_w11` and `out_w22` are unchanged.
  - This allows weights to be stored row-wise in memory.
  - When undefined, the default direct mapping applies.
- Latency and handshake are identical in both builds.

## Test plan
- Single tile:
  - Stimulus: memory [15..18]={3,5,4,6}, `base_addr`=15, `num_tiles`=1, `out_ready`=1.
  - Default build: `mem_addr`=15; cycle 3 `out_valid` with w11/w12/w21/w22 = 3/5/4/6 and `out_last`=1; `done` in cycle 4.
  - Transpose build: 3/4/5/6.
- Multi-tile with backpressure:
  - Stimulus: `num_tiles`=3, `base_addr`=0; `out_ready` low for 5 cycles on tile 1.
  - Response: `mem_addr` sequence 0,4,8; tile 1 held stable while stalled; `out_last` only on tile 2; exactly 3 handshakes and one `done`.
- Zero tiles: `num_tiles`=0 -> `done` in cycle 1, `out_valid` never asserted, `busy` high for one cycle.
- Address wrap: `base_addr`=8188, `num_tiles`=2 -> second fetch at `mem_addr`=0.
- Start while busy: `start` pulsed during tile 0 with a different `base_addr` -> ignored; transfer completes with the original addresses.
- Reset mid-transfer: reset asserted in PRESENT of tile 1 of 3 -> outputs 0 immediately, no `done`; a new `start` runs a full transfer correctly.
